// File: rtl/timer_pkg.sv
// Shared definitions for the APB timer: register offsets, control/status bit
// positions, clock-select and bus-phase enumerations, prescaler tick helper.
package timer_pkg;

    // Byte offsets of the mapped registers (paddr[1:0] is never decoded)
    localparam logic [4:0] ADDR_TDR  = 5'h00;
    localparam logic [4:0] ADDR_TCR  = 5'h04;
    localparam logic [4:0] ADDR_TSR  = 5'h08;
    localparam logic [4:0] ADDR_TIER = 5'h0C;
    localparam logic [4:0] ADDR_TCNT = 5'h10;

    // TCR bit positions; unimplemented bits are masked off on write
    localparam int TCR_LOAD = 7;
    localparam int TCR_DIR  = 5;
    localparam int TCR_EN   = 4;
    localparam logic [7:0] TCR_MASK = 8'hB3;

    // TSR bit positions
    localparam int TSR_UDF = 1;
    localparam int TSR_OVF = 0;

    typedef enum logic [1:0] {
        CKS_DIV2  = 2'd0,
        CKS_DIV4  = 2'd1,
        CKS_DIV8  = 2'd2,
        CKS_DIV16 = 2'd3
    } cks_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // True on the last count of the selected divide period
    function automatic logic prescale_tick(input logic [3:0] cnt, input cks_e cks);
        logic hit;
        case (cks)
            CKS_DIV2:  hit = cnt[0];
            CKS_DIV4:  hit = &cnt[1:0];
            CKS_DIV8:  hit = &cnt[2:0];
            CKS_DIV16: hit = &cnt;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running 4-bit divider producing a one-cycle tick every 2/4/8/16 clocks.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic pclk,
    input  logic prst,
    input  logic clr,
    input  cks_e cks,
    output logic tick
);

    logic [3:0] div_cnt_r;

    // Divider count, parked at zero while the timer is stopped or loading
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            div_cnt_r <= 4'd0;
        end else if (clr) begin
            div_cnt_r <= 4'd0;
        end else begin
            div_cnt_r <= div_cnt_r + 4'd1;
        end
    end

    // Tick decoded from the registered count so a same-edge TCR write cannot alter it
    always_comb begin
        tick = prescale_tick(div_cnt_r, cks);
    end

endmodule

// File: rtl/timer_apb_responder.sv
// APB responder with an 8-bit up/down timer, sticky under/overflow flags and
// a level interrupt. Bus response signals are registered; the write commits
// on the same edge that raises pready.
module timer_apb_responder
    import timer_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 8
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              irq
);

    // Wait count value in the last ACCESS cycle before completion
    localparam logic [2:0] WAIT_LAST = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    apb_state_e  state_r;
    logic [2:0]  wait_cnt_r;
    logic [7:0]  tdr_r;
    logic [7:0]  tcr_r;
    logic [7:0]  tcnt_r;
    logic [1:0]  tsr_r;
    logic [1:0]  tier_r;

    logic [4:0]  offset_s;
    logic        mapped_s;
    logic [31:0] rdata_s;
    logic        complete_s;
    logic        wr_en_s;
    logic        tick_s;
    logic        presc_clr_s;
    logic [7:0]  tcnt_next_s;
    logic        udf_set_s;
    logic        ovf_set_s;
    logic [1:0]  tsr_keep_s;
    logic        unused_bits_s;

    assign offset_s      = {paddr[4:2], 2'b00};
    assign wr_en_s       = complete_s & pwrite & mapped_s;
    assign presc_clr_s   = tcr_r[TCR_LOAD] | ~tcr_r[TCR_EN];
    assign irq           = |(tsr_r & tier_r);
    assign unused_bits_s = ^{paddr[ADDR_W-1:5], paddr[1:0], pwdata[31:8]};

    timer_prescaler u_prescaler (
        .pclk (pclk),
        .prst (prst),
        .clr  (presc_clr_s),
        .cks  (cks_e'(tcr_r[1:0])),
        .tick (tick_s)
    );

    // Address decode and read mux; unmapped offsets read zero and flag an error
    always_comb begin
        mapped_s = 1'b1;
        rdata_s  = 32'd0;
        case (offset_s)
            ADDR_TDR:  rdata_s = {24'd0, tdr_r};
            ADDR_TCR:  rdata_s = {24'd0, tcr_r};
            ADDR_TSR:  rdata_s = {30'd0, tsr_r};
            ADDR_TIER: rdata_s = {30'd0, tier_r};
            ADDR_TCNT: rdata_s = {24'd0, tcnt_r};
            default: begin
                mapped_s = 1'b0;
                rdata_s  = 32'd0;
            end
        endcase
    end

    // Transfer completes on the edge that will raise pready
    always_comb begin
        if (state_r == IDLE) begin
            complete_s = psel && !penable && (WAIT_STATES == 0);
        end else if (state_r == SETUP) begin
            complete_s = psel && penable && (wait_cnt_r == WAIT_LAST);
        end else begin
            complete_s = 1'b0;
        end
    end

    // Bus phase tracking, wait-state counting and registered response
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_r    <= IDLE;
            wait_cnt_r <= 3'd0;
            pready     <= 1'b0;
            pslverr    <= 1'b0;
            prdata     <= 32'd0;
        end else begin
            pready  <= complete_s;
            pslverr <= complete_s & ~mapped_s;
            prdata  <= (complete_s && !pwrite) ? rdata_s : 32'd0;
            case (state_r)
                IDLE: begin
                    wait_cnt_r <= 3'd0;
                    if (psel && !penable) begin
                        state_r <= (WAIT_STATES == 0) ? ACCESS : SETUP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETUP: begin
                    if (!psel) begin
                        state_r    <= IDLE;
                        wait_cnt_r <= 3'd0;
                    end else if (complete_s) begin
                        state_r <= ACCESS;
                    end else if (penable) begin
                        state_r    <= SETUP;
                        wait_cnt_r <= wait_cnt_r + 3'd1;
                    end else begin
                        state_r <= SETUP;
                    end
                end
                ACCESS: begin
                    state_r    <= IDLE;
                    wait_cnt_r <= 3'd0;
                end
                default: begin
                    state_r    <= IDLE;
                    wait_cnt_r <= 3'd0;
                end
            endcase
        end
    end

    // Counter next value and wrap detection; LOAD overrides counting
    always_comb begin
        tcnt_next_s = tcnt_r;
        udf_set_s   = 1'b0;
        ovf_set_s   = 1'b0;
        if (tcr_r[TCR_LOAD]) begin
            tcnt_next_s = tdr_r;
        end else if (tcr_r[TCR_EN] && tick_s) begin
            if (tcr_r[TCR_DIR]) begin
                tcnt_next_s = tcnt_r - 8'd1;
                udf_set_s   = (tcnt_r == 8'h00);
            end else begin
                tcnt_next_s = tcnt_r + 8'd1;
                ovf_set_s   = (tcnt_r == 8'hFF);
            end
        end else begin
            tcnt_next_s = tcnt_r;
        end
    end

    // Status bits written as 0 are cleared; a hardware set on the same edge wins below
    always_comb begin
        if (wr_en_s && (offset_s == ADDR_TSR)) begin
            tsr_keep_s = tsr_r & pwdata[1:0];
        end else begin
            tsr_keep_s = tsr_r;
        end
    end

    // Register file, counter and sticky flags
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            tdr_r  <= 8'd0;
            tcr_r  <= 8'd0;
            tier_r <= 2'd0;
            tcnt_r <= 8'd0;
            tsr_r  <= 2'd0;
        end else begin
            if (wr_en_s && (offset_s == ADDR_TDR)) begin
                tdr_r <= pwdata[7:0];
            end
            if (wr_en_s && (offset_s == ADDR_TCR)) begin
                tcr_r <= pwdata[7:0] & TCR_MASK;
            end
            if (wr_en_s && (offset_s == ADDR_TIER)) begin
                tier_r <= pwdata[1:0];
            end
            tcnt_r          <= tcnt_next_s;
            tsr_r[TSR_UDF]  <= tsr_keep_s[TSR_UDF] | udf_set_s;
            tsr_r[TSR_OVF]  <= tsr_keep_s[TSR_OVF] | ovf_set_s;
        end
    end

endmodule

// File: tb/tb_timer_apb_responder.sv
// Directed bench: one zero-wait instance for timer behaviour, one three-wait
// instance for handshake timing, abort and reset-during-transfer.
module tb_timer_apb_responder;
    import timer_pkg::*;

    logic        pclk;
    logic        prst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic        sel3;

    logic        psel0;
    logic        psel3;
    logic [31:0] prdata0;
    logic [31:0] prdata3;
    logic        pready0;
    logic        pready3;
    logic        pslverr0;
    logic        pslverr3;
    logic        irq0;
    logic        irq3;

    int checks;
    int errors;

    assign psel0 = psel & ~sel3;
    assign psel3 = psel & sel3;

    timer_apb_responder #(.WAIT_STATES(0), .ADDR_W(8)) dut (
        .pclk (pclk), .prst (prst), .psel (psel0), .penable (penable),
        .pwrite (pwrite), .paddr (paddr), .pwdata (pwdata),
        .prdata (prdata0), .pready (pready0), .pslverr (pslverr0), .irq (irq0)
    );

    timer_apb_responder #(.WAIT_STATES(3), .ADDR_W(8)) dut3 (
        .pclk (pclk), .prst (prst), .psel (psel3), .penable (penable),
        .pwrite (pwrite), .paddr (paddr), .pwdata (pwdata),
        .prdata (prdata3), .pready (pready3), .pslverr (pslverr3), .irq (irq3)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer starting just after a rising edge; checks the wait count
    task automatic xfer(input string tag, input logic wr, input logic [7:0] a,
                        input logic [31:0] d, output logic [31:0] rdata, output logic err);
        int waits;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits = 0;
        while ((sel3 ? pready3 : pready0) !== 1'b1 && waits < 16) begin
            @(posedge pclk); #1;
            waits++;
        end
        rdata = sel3 ? prdata3 : prdata0;
        err   = sel3 ? pslverr3 : pslverr0;
        check({tag, "_waits"}, 32'(waits), sel3 ? 32'd3 : 32'd0);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [7:0] a, input logic [31:0] d, input logic exp_err);
        logic [31:0] rd_v;
        logic        err_v;
        xfer(tag, 1'b1, a, d, rd_v, err_v);
        check({tag, "_err"}, {31'd0, err_v}, {31'd0, exp_err});
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp_d, input logic exp_err);
        logic [31:0] rd_v;
        logic        err_v;
        xfer(tag, 1'b0, a, 32'd0, rd_v, err_v);
        check({tag, "_data"}, rd_v, exp_d);
        check({tag, "_err"}, {31'd0, err_v}, {31'd0, exp_err});
    endtask

    initial begin
        checks = 0; errors = 0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'd0; pwdata = 32'd0; sel3 = 1'b0;
        prst = 1'b1;
        repeat (3) @(posedge pclk);
        #1 prst = 1'b0;
        @(posedge pclk); #1;

        // Reset state and empty register map
        check("rst_pready", {31'd0, pready0}, 32'd0);
        check("rst_prdata", prdata0, 32'd0);
        check("rst_pslverr", {31'd0, pslverr0}, 32'd0);
        check("rst_irq", {31'd0, irq0}, 32'd0);
        for (int i = 0; i < 5; i++) rd("rst_read", 8'(i * 4), 32'd0, 1'b0);
        rd("unmapped_rd", 8'h14, 32'd0, 1'b1);
        wr("tcnt_wr", 8'h10, 32'h55, 1'b0);
        rd("tcnt_ro", 8'h10, 32'd0, 1'b0);
        wr("unmapped_wr", 8'h1C, 32'hFF, 1'b1);

        // Down count from 255 at /2: TCR=0x30 commits at E0, UDF at E512
        wr("tdr255", 8'h00, 32'hFF, 1'b0);
        wr("tcr_load", 8'h04, 32'h80, 1'b0);
        wr("tcr_down", 8'h04, 32'h30, 1'b0);
        repeat (498) @(posedge pclk);
        #1;
        rd("tsr_e500", 8'h08, 32'h0, 1'b0);
        repeat (9) @(posedge pclk);
        #1;
        rd("tcnt_e511", 8'h10, 32'h00, 1'b0);
        rd("tsr_e513", 8'h08, 32'h2, 1'b0);

        // Interrupt enable and clear by writing zero
        check("irq_masked", {31'd0, irq0}, 32'd0);
        wr("tier_udf", 8'h0C, 32'h2, 1'b0);
        check("irq_udf", {31'd0, irq0}, 32'd1);
        wr("tsr_clear", 8'h08, 32'h0, 1'b0);
        check("irq_cleared", {31'd0, irq0}, 32'd0);
        rd("tsr_after_clr", 8'h08, 32'h0, 1'b0);
        wr("tcr_stop", 8'h04, 32'h00, 1'b0);

        // Up count from 0xFE at /16 (EN set): OVF on the second tick, 32 clocks in
        wr("tdr_fe", 8'h00, 32'hFE, 1'b0);
        wr("tcr_load_up", 8'h04, 32'h83, 1'b0);
        wr("tcr_up16", 8'h04, 32'h13, 1'b0);
        repeat (30) @(posedge pclk);
        #1;
        rd("tsr_e32", 8'h08, 32'h0, 1'b0);
        rd("tsr_e34", 8'h08, 32'h1, 1'b0);
        rd("tcnt_wrap", 8'h10, 32'h00, 1'b0);
        wr("tsr_w1", 8'h08, 32'h1, 1'b0);
        rd("tsr_ovf_kept", 8'h08, 32'h1, 1'b0);
        check("irq_ovf_masked", {31'd0, irq0}, 32'd0);
        wr("tier_both", 8'h0C, 32'h3, 1'b0);
        check("irq_ovf", {31'd0, irq0}, 32'd1);
        wr("tcr_stop2", 8'h04, 32'h00, 1'b0);

        // UDF set on the same edge as a TSR clear: TCR=0x30 at E0, TSR=0 at E2 = first tick
        wr("tdr_zero", 8'h00, 32'h00, 1'b0);
        wr("tcr_load0", 8'h04, 32'h80, 1'b0);
        wr("tsr_preclr", 8'h08, 32'h0, 1'b0);
        rd("tsr_pre", 8'h08, 32'h0, 1'b0);
        wr("tcr_race", 8'h04, 32'h30, 1'b0);
        wr("tsr_race", 8'h08, 32'h0, 1'b0);
        rd("tsr_set_wins", 8'h08, 32'h2, 1'b0);
        check("irq_race", {31'd0, irq0}, 32'd1);
        wr("tcr_stop3", 8'h04, 32'h00, 1'b0);

        // Three-wait-state instance
        sel3 = 1'b1;
        wr("w3_tdr", 8'h00, 32'h5A, 1'b0);
        rd("w3_tdr_rd", 8'h00, 32'h5A, 1'b0);
        wr("w3_tcr", 8'h04, 32'hFF, 1'b0);
        rd("w3_tcr_mask", 8'h04, 32'hB3, 1'b0);
        wr("w3_tcr_off", 8'h04, 32'h00, 1'b0);
        rd("w3_unmapped", 8'h14, 32'd0, 1'b1);

        // psel dropped during a wait cycle: no write, back to IDLE
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h77;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        check("abort_wait", {31'd0, pready3}, 32'd0);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge pclk); #1;
        check("abort_idle", 32'(dut3.state_r), 32'(IDLE));
        check("abort_pready", {31'd0, pready3}, 32'd0);
        rd("abort_tdr", 8'h00, 32'h5A, 1'b0);

        // Reset during a wait cycle: no partial write, all registers cleared
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h11;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        prst = 1'b1;
        #1;
        check("rst_mid_pready", {31'd0, pready3}, 32'd0);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge pclk); #1;
        prst = 1'b0;
        @(posedge pclk); #1;
        rd("rst_mid_tdr", 8'h00, 32'h00, 1'b0);
        sel3 = 1'b0;
        rd("rst_dut0_tier", 8'h0C, 32'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
